// File: rtl/dual_issue_unit_pkg.sv
// Shared types for the dual-issue unit: pipe/format/opcode enums, the decoded
// instruction record, the idle-pipe constants and the buffer state encoding.
package dual_issue_unit_pkg;

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} pipe_e;

  typedef enum logic [2:0] {RR, RRR, RI7, RI10, RI16, RI18} format_e;

  typedef enum logic [4:0] {
    OPC_NOP, OPC_LNOP, OPC_A, OPC_SF, OPC_AND, OPC_OR, OPC_AI, OPC_SHLI,
    OPC_IL, OPC_ILA, OPC_FMA, OPC_LQD, OPC_LQA, OPC_ROTQBI, OPC_SHUFB
  } opcode_e;

  typedef enum logic [1:0] {S_EMPTY, S_PAIR, S_SINGLE} state_e;

  // rd_* flag the source fields the format really carries, wr_rt a real target.
  typedef struct packed {
    opcode_e     opcode;
    format_e     format;
    pipe_e       pipe;
    logic        valid;
    logic [6:0]  rt;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rc;
    logic        rd_ra;
    logic        rd_rb;
    logic        rd_rc;
    logic        wr_rt;
    logic [6:0]  i7;
    logic [9:0]  i10;
    logic [15:0] i16;
    logic [17:0] i18;
  } decoded_instr_t;

  localparam decoded_instr_t NOP = '{
    opcode: OPC_NOP, format: RR, pipe: EVEN, valid: 1'b1,
    rt: 7'd0, ra: 7'd0, rb: 7'd0, rc: 7'd0,
    rd_ra: 1'b0, rd_rb: 1'b0, rd_rc: 1'b0, wr_rt: 1'b0,
    i7: 7'd0, i10: 10'd0, i16: 16'd0, i18: 18'd0
  };

  localparam decoded_instr_t LNOP = '{
    opcode: OPC_LNOP, format: RR, pipe: ODD, valid: 1'b1,
    rt: 7'd0, ra: 7'd0, rb: 7'd0, rc: 7'd0,
    rd_ra: 1'b0, rd_rb: 1'b0, rd_rc: 1'b0, wr_rt: 1'b0,
    i7: 7'd0, i10: 10'd0, i16: 16'd0, i18: 18'd0
  };

endpackage

// File: rtl/dual_issue_unit_if.sv
// Fetch handshake plus per-pipe issue bus of the dual-issue unit.
// master = fetch/consumer side, slave = the issue unit.
interface dual_issue_unit_if;
  import dual_issue_unit_pkg::*;

  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] instr_0;
  logic [31:0] instr_1;
  logic [31:0] fetch_pc;
  logic        flush;
  opcode_e     ep_opcode;
  opcode_e     op_opcode;
  logic [6:0]  ra_ep_address;
  logic [6:0]  rb_ep_address;
  logic [6:0]  rc_ep_address;
  logic [6:0]  rt_ep_address;
  logic [6:0]  ra_op_address;
  logic [6:0]  rb_op_address;
  logic [6:0]  rt_op_address;
  logic [6:0]  I7_ep;
  logic [9:0]  I10_ep;
  logic [15:0] I16_ep;
  logic [17:0] I18_ep;
  logic [6:0]  I7_op;
  logic [9:0]  I10_op;
  logic [15:0] I16_op;
  logic [17:0] I18_op;
  logic [31:0] PC_output;
  logic        illegal_instr;

  modport master (
    output fetch_valid, instr_0, instr_1, fetch_pc, flush,
    input  fetch_ready, ep_opcode, op_opcode,
    input  ra_ep_address, rb_ep_address, rc_ep_address, rt_ep_address,
    input  ra_op_address, rb_op_address, rt_op_address,
    input  I7_ep, I10_ep, I16_ep, I18_ep, I7_op, I10_op, I16_op, I18_op,
    input  PC_output, illegal_instr
  );

  modport slave (
    input  fetch_valid, instr_0, instr_1, fetch_pc, flush,
    output fetch_ready, ep_opcode, op_opcode,
    output ra_ep_address, rb_ep_address, rc_ep_address, rt_ep_address,
    output ra_op_address, rb_op_address, rt_op_address,
    output I7_ep, I10_ep, I16_ep, I18_ep, I7_op, I10_op, I16_op, I18_op,
    output PC_output, illegal_instr
  );

endinterface

// File: rtl/dual_issue_unit_instr_decoder.sv
// Combinational decoder: 32-bit SPU-style word -> decoded_instr_t.
// Unknown words come back as an even-pipe nop with valid=0.
module instr_decoder
  import dual_issue_unit_pkg::*;
(
  input  logic [31:0]    word,
  output decoded_instr_t dec
);

  opcode_e opc;
  format_e fmt;
  pipe_e   pipe;
  logic    known;
  logic    bare;

  // Classify the opcode; patterns are chosen so no two prefixes overlap.
  always_comb begin
    opc   = OPC_NOP;
    fmt   = RR;
    pipe  = EVEN;
    known = 1'b1;
    bare  = 1'b0;
    casez (word[31:21])
      11'b1110???????: begin opc = OPC_FMA;    fmt = RRR;  end
      11'b1011???????: begin opc = OPC_SHUFB;  fmt = RRR;  pipe = ODD; end
      11'b0100001????: begin opc = OPC_ILA;    fmt = RI18; end
      11'b00011100???: begin opc = OPC_AI;     fmt = RI10; end
      11'b00110100???: begin opc = OPC_LQD;    fmt = RI10; pipe = ODD; end
      11'b010000001??: begin opc = OPC_IL;     fmt = RI16; end
      11'b001100001??: begin opc = OPC_LQA;    fmt = RI16; pipe = ODD; end
      11'b00011000000: begin opc = OPC_A;      fmt = RR;   end
      11'b00001000000: begin opc = OPC_SF;     fmt = RR;   end
      11'b00011000001: begin opc = OPC_AND;    fmt = RR;   end
      11'b00001000001: begin opc = OPC_OR;     fmt = RR;   end
      11'b00001111011: begin opc = OPC_SHLI;   fmt = RI7;  end
      11'b00111011000: begin opc = OPC_ROTQBI; fmt = RR;   pipe = ODD; end
      11'b01000000001: begin opc = OPC_NOP;    bare = 1'b1; end
      11'b00000000001: begin opc = OPC_LNOP;   bare = 1'b1; pipe = ODD; end
      default:         begin known = 1'b0;     bare = 1'b1; end
    endcase
  end

  // Extract only the fields the format carries; everything else stays zero.
  always_comb begin
    dec = NOP;
    if (!known) begin
      dec.valid = 1'b0;
    end else if (bare) begin
      dec = (pipe == ODD) ? LNOP : NOP;
    end else begin
      dec.opcode = opc;
      dec.format = fmt;
      dec.pipe   = pipe;
      dec.rt     = word[6:0];
      dec.wr_rt  = 1'b1;
      case (fmt)
        RR: begin
          dec.ra    = word[13:7];
          dec.rb    = word[20:14];
          dec.rd_ra = 1'b1;
          dec.rd_rb = 1'b1;
        end
        RRR: begin
          dec.rt    = word[27:21];
          dec.rb    = word[20:14];
          dec.ra    = word[13:7];
          dec.rc    = word[6:0];
          dec.rd_ra = 1'b1;
          dec.rd_rb = 1'b1;
          dec.rd_rc = 1'b1;
        end
        RI7: begin
          dec.i7    = word[20:14];
          dec.ra    = word[13:7];
          dec.rd_ra = 1'b1;
        end
        RI10: begin
          dec.i10   = word[23:14];
          dec.ra    = word[13:7];
          dec.rd_ra = 1'b1;
        end
        RI16:    dec.i16 = word[22:7];
        RI18:    dec.i18 = word[24:7];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dual_issue_unit.sv
// Dual-issue unit: two-slot pair buffer feeding an even and an odd pipe.
// Build option: define DUAL_ISSUE_UNIT_DUAL_EN to let a hazard-free pair on
// different pipes issue in one cycle; otherwise at most one instruction/cycle.
module dual_issue_unit
  import dual_issue_unit_pkg::*;
(
  input logic              clock,
  input logic              reset,
  dual_issue_unit_if.slave bus
);

  state_e         state, state_nxt;
  logic           alive;
  logic [31:0]    slot0_p0, slot1_p0, pc_p0;
  decoded_instr_t dec0, dec1;
  decoded_instr_t ep_nxt, op_nxt, ep_p1, op_p1;
  logic [31:0]    pc_even, pc_odd, pc_nxt, pc_p1;
  logic           has_odd, ill_nxt, ill_p1;
  logic           issue0, issue1, raw, can_dual, ready, take;
  logic           unused_bits;

  instr_decoder u_dec0 (.word(slot0_p0), .dec(dec0));
  instr_decoder u_dec1 (.word(slot1_p0), .dec(dec1));

  assign raw = dec0.wr_rt &&
               ((dec1.rd_ra && dec1.ra == dec0.rt) ||
                (dec1.rd_rb && dec1.rb == dec0.rt) ||
                (dec1.rd_rc && dec1.rc == dec0.rt));

`ifdef DUAL_ISSUE_UNIT_DUAL_EN
  assign can_dual = (dec0.pipe != dec1.pipe) && !raw;
`else
  assign can_dual = 1'b0;
`endif

  // Buffer FSM: decide what issues this cycle and whether a new pair fits.
  always_comb begin
    state_nxt = state;
    issue0    = 1'b0;
    issue1    = 1'b0;
    ready     = 1'b0;
    case (state)
      S_EMPTY:  ready = 1'b1;
      S_PAIR: begin
        issue0 = 1'b1;
        if (can_dual) begin
          issue1 = 1'b1;
          ready  = 1'b1;
        end
      end
      S_SINGLE: begin
        issue1 = 1'b1;
        ready  = 1'b1;
      end
      default: ;
    endcase
    ready = ready && alive && !bus.flush;
    take  = bus.fetch_valid && ready;
    if (bus.flush) begin
      issue0    = 1'b0;
      issue1    = 1'b0;
      state_nxt = S_EMPTY;
    end else if (take) begin
      state_nxt = S_PAIR;
    end else if (state == S_PAIR && !can_dual) begin
      state_nxt = S_SINGLE;
    end else begin
      state_nxt = S_EMPTY;
    end
  end

  // Route issued slots onto their pipes; idle pipes carry nop/lnop.
  always_comb begin
    ep_nxt  = NOP;
    op_nxt  = LNOP;
    pc_even = 32'd0;
    pc_odd  = 32'd0;
    has_odd = 1'b0;
    ill_nxt = 1'b0;
    if (issue0) begin
      if (dec0.pipe == ODD) begin
        op_nxt  = dec0;
        pc_odd  = pc_p0;
        has_odd = 1'b1;
      end else begin
        ep_nxt  = dec0;
        pc_even = pc_p0;
      end
      ill_nxt = ill_nxt | ~dec0.valid;
    end
    if (issue1) begin
      if (dec1.pipe == ODD) begin
        op_nxt  = dec1;
        pc_odd  = pc_p0 + 32'd4;
        has_odd = 1'b1;
      end else begin
        ep_nxt  = dec1;
        pc_even = pc_p0 + 32'd4;
      end
      ill_nxt = ill_nxt | ~dec1.valid;
    end
    pc_nxt = has_odd ? pc_odd : pc_even;
  end

  // Control and issue registers; alive delays fetch_ready one edge past reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_EMPTY;
      alive  <= 1'b0;
      ep_p1  <= NOP;
      op_p1  <= LNOP;
      pc_p1  <= 32'd0;
      ill_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      alive  <= 1'b1;
      ep_p1  <= ep_nxt;
      op_p1  <= op_nxt;
      pc_p1  <= pc_nxt;
      ill_p1 <= ill_nxt;
    end
  end

  // ---- stage p0: pair buffer, loaded on every accepted transfer ----
  always_ff @(posedge clock) begin
    if (take) begin
      slot0_p0 <= bus.instr_0;
      slot1_p0 <= bus.instr_1;
      pc_p0    <= bus.fetch_pc;
    end
  end

  // ---- stage p1: registered issue outputs ----
  assign bus.fetch_ready   = ready;
  assign bus.ep_opcode     = ep_p1.opcode;
  assign bus.rt_ep_address = ep_p1.rt;
  assign bus.ra_ep_address = ep_p1.ra;
  assign bus.rb_ep_address = ep_p1.rb;
  assign bus.rc_ep_address = ep_p1.rc;
  assign bus.I7_ep         = ep_p1.i7;
  assign bus.I10_ep        = ep_p1.i10;
  assign bus.I16_ep        = ep_p1.i16;
  assign bus.I18_ep        = ep_p1.i18;
  assign bus.op_opcode     = op_p1.opcode;
  assign bus.rt_op_address = op_p1.rt;
  assign bus.ra_op_address = op_p1.ra;
  assign bus.rb_op_address = op_p1.rb;
  assign bus.I7_op         = op_p1.i7;
  assign bus.I10_op        = op_p1.i10;
  assign bus.I16_op        = op_p1.i16;
  assign bus.I18_op        = op_p1.i18;
  assign bus.PC_output     = pc_p1;
  assign bus.illegal_instr = ill_p1;

  // Record fields (format, flags, odd rc) that no output consumes.
  assign unused_bits = ^{dec0, dec1, ep_p1, op_p1, raw};

endmodule

// File: tb/tb_dual_issue_unit.sv
// Self-checking bench for dual_issue_unit: directed pairs from the ISA
// examples plus randomized traffic, compared against a queue-based model.
// Follows DUAL_ISSUE_UNIT_DUAL_EN exactly like the design.
module tb_dual_issue_unit;
  import dual_issue_unit_pkg::*;

  typedef struct {
    opcode_e     opc;
    format_e     fmt;
    pipe_e       pipe;
    bit          bare;
    bit          ill;
    logic [6:0]  rt, ra, rb, rc;
    logic [17:0] imm;
    logic [31:0] word;
    logic [31:0] pc;
  } minst_t;

  logic clock;
  logic reset;
  dual_issue_unit_if bus();

  dual_issue_unit dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  minst_t bq[$];
  bit     alive_m;
  opcode_e     e_ep_opc, e_op_opc;
  logic [95:0] e_ep_vec, e_op_vec;
  logic [31:0] e_pc_even, e_pc_odd;
  bit          e_has_odd, e_ill;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Build an instruction from the ISA encoding tables.
  function automatic minst_t mk(input int k, input logic [6:0] rt, input logic [6:0] ra,
                                input logic [6:0] rb, input logic [6:0] rc, input logic [17:0] imm);
    minst_t m;
    m.rt = rt; m.ra = ra; m.rb = rb; m.rc = rc; m.imm = 18'd0;
    m.bare = 1'b0; m.ill = 1'b0; m.pc = 32'd0; m.pipe = EVEN; m.fmt = RR; m.opc = OPC_NOP;
    case (k)
      0:  begin m.opc = OPC_A;      m.word = {11'b00011000000, rb, ra, rt}; end
      1:  begin m.opc = OPC_SF;     m.word = {11'b00001000000, rb, ra, rt}; end
      2:  begin m.opc = OPC_AND;    m.word = {11'b00011000001, rb, ra, rt}; end
      3:  begin m.opc = OPC_OR;     m.word = {11'b00001000001, rb, ra, rt}; end
      4:  begin m.opc = OPC_AI;   m.fmt = RI10; m.imm = {8'd0, imm[9:0]}; m.word = {8'b00011100, imm[9:0], ra, rt}; end
      5:  begin m.opc = OPC_SHLI; m.fmt = RI7;  m.imm = {11'd0, imm[6:0]}; m.word = {11'b00001111011, imm[6:0], ra, rt}; end
      6:  begin m.opc = OPC_IL;   m.fmt = RI16; m.imm = {2'd0, imm[15:0]}; m.word = {9'b010000001, imm[15:0], rt}; end
      7:  begin m.opc = OPC_ILA;  m.fmt = RI18; m.imm = imm; m.word = {7'b0100001, imm, rt}; end
      8:  begin m.opc = OPC_FMA;  m.fmt = RRR;  m.word = {4'b1110, rt, rb, ra, rc}; end
      9:  begin m.opc = OPC_LQD;  m.fmt = RI10; m.pipe = ODD; m.imm = {8'd0, imm[9:0]}; m.word = {8'b00110100, imm[9:0], ra, rt}; end
      10: begin m.opc = OPC_LQA;  m.fmt = RI16; m.pipe = ODD; m.imm = {2'd0, imm[15:0]}; m.word = {9'b001100001, imm[15:0], rt}; end
      11: begin m.opc = OPC_ROTQBI; m.pipe = ODD; m.word = {11'b00111011000, rb, ra, rt}; end
      12: begin m.opc = OPC_SHUFB; m.fmt = RRR; m.pipe = ODD; m.word = {4'b1011, rt, rb, ra, rc}; end
      13: begin m.opc = OPC_NOP;  m.bare = 1'b1; m.word = {11'b01000000001, 21'd0}; end
      14: begin m.opc = OPC_LNOP; m.bare = 1'b1; m.pipe = ODD; m.word = {11'b00000000001, 21'd0}; end
      default: begin m.bare = 1'b1; m.ill = 1'b1; m.word = {4'b1111, imm, rt, 3'b000}; end
    endcase
    return m;
  endfunction

  function automatic minst_t rand_inst();
    return mk(int'($urandom_range(0, 15)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
              7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 18'($urandom));
  endfunction

  // Register/immediate fields a pipe shows for an instruction (odd pipe has no rc).
  function automatic logic [95:0] fields(input minst_t m, input bit even);
    logic [6:0] rt, ra, rb, rc, i7;
    logic [9:0] i10;
    logic [15:0] i16;
    logic [17:0] i18;
    rt = 0; ra = 0; rb = 0; rc = 0; i7 = 0; i10 = 0; i16 = 0; i18 = 0;
    if (!m.bare) begin
      rt = m.rt;
      case (m.fmt)
        RR:   begin ra = m.ra; rb = m.rb; end
        RRR:  begin ra = m.ra; rb = m.rb; rc = m.rc; end
        RI7:  begin ra = m.ra; i7 = m.imm[6:0]; end
        RI10: begin ra = m.ra; i10 = m.imm[9:0]; end
        RI16: i16 = m.imm[15:0];
        default: i18 = m.imm;
      endcase
    end
    if (!even) rc = 7'd0;
    return {17'd0, rt, ra, rb, rc, i7, i10, i16, i18};
  endfunction

  // True when the younger instruction reads the register the older one writes.
  function automatic bit raw_dep(input minst_t o, input minst_t y);
    if (o.bare || y.bare) return 1'b0;
    case (y.fmt)
      RR:        return (y.ra == o.rt) || (y.rb == o.rt);
      RRR:       return (y.ra == o.rt) || (y.rb == o.rt) || (y.rc == o.rt);
      RI7, RI10: return y.ra == o.rt;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic bit can_pair(input minst_t o, input minst_t y);
`ifdef DUAL_ISSUE_UNIT_DUAL_EN
    return (o.pipe != y.pipe) && !raw_dep(o, y);
`else
    return 1'b0 & (o.pipe != y.pipe);
`endif
  endfunction

  task automatic set_idle();
    e_ep_opc = OPC_NOP;  e_ep_vec = '0;
    e_op_opc = OPC_LNOP; e_op_vec = '0;
    e_pc_even = 32'd0; e_pc_odd = 32'd0; e_has_odd = 1'b0; e_ill = 1'b0;
  endtask

  task automatic put(input minst_t m);
    if (m.pipe == ODD) begin
      e_op_opc = m.opc; e_op_vec = fields(m, 1'b0); e_pc_odd = m.pc; e_has_odd = 1'b1;
    end else begin
      e_ep_opc = m.opc; e_ep_vec = fields(m, 1'b1); e_pc_even = m.pc;
    end
    if (m.ill) e_ill = 1'b1;
  endtask

  task automatic check_outputs();
    check_eq("ep_opcode", {91'd0, bus.ep_opcode}, {91'd0, e_ep_opc});
    check_eq("op_opcode", {91'd0, bus.op_opcode}, {91'd0, e_op_opc});
    check_eq("ep_fields", {17'd0, bus.rt_ep_address, bus.ra_ep_address, bus.rb_ep_address,
                           bus.rc_ep_address, bus.I7_ep, bus.I10_ep, bus.I16_ep, bus.I18_ep}, e_ep_vec);
    check_eq("op_fields", {17'd0, bus.rt_op_address, bus.ra_op_address, bus.rb_op_address,
                           7'd0, bus.I7_op, bus.I10_op, bus.I16_op, bus.I18_op}, e_op_vec);
    check_eq("PC_output", {64'd0, bus.PC_output}, {64'd0, (e_has_odd ? e_pc_odd : e_pc_even)});
    check_eq("illegal_instr", {95'd0, bus.illegal_instr}, {95'd0, e_ill});
  endtask

  // One clock cycle: drive at negedge, check ready, advance model, check outputs.
  task automatic step(input bit fv, input bit fl, input minst_t a, input minst_t b, input logic [31:0] pc);
    bit rdy, dual;
    minst_t ma, mb;
    bus.fetch_valid = fv; bus.flush = fl;
    bus.instr_0 = a.word; bus.instr_1 = b.word; bus.fetch_pc = pc;
    #1;
    dual = (bq.size() == 2) ? can_pair(bq[0], bq[1]) : 1'b0;
    rdy  = alive_m && !fl && (bq.size() != 2 || dual);
    check_eq("fetch_ready", {95'd0, bus.fetch_ready}, {95'd0, rdy});
    set_idle();
    if (fl) begin
      bq.delete();
    end else begin
      if (bq.size() == 2 && dual) begin
        put(bq[0]); put(bq[1]); bq.delete();
      end else if (bq.size() > 0) begin
        put(bq[0]); void'(bq.pop_front());
      end
      if (fv && rdy) begin
        ma = a; ma.pc = pc; mb = b; mb.pc = pc + 32'd4;
        bq.push_back(ma); bq.push_back(mb);
      end
    end
    @(posedge clock);
    alive_m = 1'b1;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    minst_t z;
    z = mk(13, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, z, z, 32'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic reset_async();
    #2 reset = 1'b0;
    #1;
    bq.delete(); alive_m = 1'b0; set_idle();
    check_outputs();
    check_eq("fetch_ready_rst", {95'd0, bus.fetch_ready}, 96'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    minst_t i_a, i_lqd5, i_ai, i_lqd3, i_bad, i_lnop, x, y;
    reset = 1'b0; alive_m = 1'b0;
    bus.fetch_valid = 1'b0; bus.flush = 1'b0;
    bus.instr_0 = 32'd0; bus.instr_1 = 32'd0; bus.fetch_pc = 32'd0;
    repeat (2) @(negedge clock);
    set_idle();
    check_outputs();
    check_eq("fetch_ready_rst", {95'd0, bus.fetch_ready}, 96'd0);
    reset = 1'b1;

    i_a    = mk(0, 7'd3, 7'd1, 7'd2, 7'd0, 18'd0);
    i_lqd5 = mk(9, 7'd4, 7'd5, 7'd0, 7'd0, 18'd0);
    i_ai   = mk(4, 7'd6, 7'd3, 7'd0, 7'd0, 18'd5);
    i_lqd3 = mk(9, 7'd4, 7'd3, 7'd0, 7'd0, 18'd0);
    i_bad  = mk(15, 7'd0, 7'd0, 7'd0, 7'd0, 18'd0);
    i_bad.word = 32'hFFFF_FFFF;
    i_lnop = mk(14, 0, 0, 0, 0, 0);

    idle(1);
    // independent even/odd pair
    step(1'b1, 1'b0, i_a, i_lqd5, 32'h100);
    idle(3);
    // both even: structural split
    step(1'b1, 1'b0, i_a, i_ai, 32'h200);
    idle(3);
    // RAW on r3
    step(1'b1, 1'b0, i_a, i_lqd3, 32'h300);
    idle(3);
    // flush while SINGLE with a pair on offer
    step(1'b1, 1'b0, i_a, i_ai, 32'h400);
    step(1'b0, 1'b0, i_a, i_ai, 32'h0);
    step(1'b1, 1'b1, i_a, i_lqd5, 32'h500);
    idle(2);
    // undecodable word in either slot
    step(1'b1, 1'b0, i_bad, i_lnop, 32'h600);
    idle(3);
    step(1'b1, 1'b0, i_a, i_bad, 32'h640);
    idle(3);
    // back-to-back pairs
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i_a, i_lqd5, 32'h700 + 32'(i * 8));
    idle(3);
    // reset in the middle of a buffered pair, then a normal pair
    step(1'b1, 1'b0, i_a, i_lqd5, 32'h800);
    step(1'b1, 1'b0, i_a, i_ai, 32'h808);
    reset_async();
    step(1'b1, 1'b0, i_a, i_lqd5, 32'h900);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      x = rand_inst();
      y = rand_inst();
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), x, y, {$urandom, 2'b00} >> 2 << 2);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
